// File: rtl/md_pkg.sv
// -----------------------------------------------------------------------------
// md_pkg
// Shared definitions for the multiply/divide scheduler and its arithmetic
// datapath. It holds the MD operation codes, the scheduler state encoding,
// and a helper that tells whether an operation occupies the unit for
// several cycles.
// -----------------------------------------------------------------------------
package md_pkg;

    localparam int unsigned MD_OP_W = 4;

    // Operation codes presented on md_op. Codes 10..15 are undefined and are
    // treated as no-ops by the scheduler.
    typedef enum logic [MD_OP_W-1:0] {
        MD_MULT  = 4'd0,
        MD_MULTU = 4'd1,
        MD_DIV   = 4'd2,
        MD_DIVU  = 4'd3,
        MD_MADD  = 4'd4,
        MD_MADDU = 4'd5,
        MD_MSUB  = 4'd6,
        MD_MSUBU = 4'd7,
        MD_MTHI  = 4'd8,
        MD_MTLO  = 4'd9
    } md_op_e;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } md_state_e;

    // Every code up to and including msubu goes through the down-counter;
    // mthi/mtlo write in a single cycle and undefined codes do nothing.
    function automatic logic is_multicycle(input logic [MD_OP_W-1:0] op);
        return (op <= 4'(MD_MSUBU));
    endfunction

    // Divides use the longer latency.
    function automatic logic is_divide(input logic [MD_OP_W-1:0] op);
        return (op == 4'(MD_DIV)) || (op == 4'(MD_DIVU));
    endfunction

endpackage : md_pkg

// File: rtl/md_arith.sv
// -----------------------------------------------------------------------------
// md_arith
// Purely combinational 64-bit result for one MD operation. The scheduler
// samples this into its temp register on the start cycle, so the current
// {hi,lo} seen here is the value at start.
//
// Ports:
//   op      in  4   operation code (md_pkg::md_op_e)
//   src_a   in  32  rs operand
//   src_b   in  32  rt operand
//   hi      in  32  current HI register
//   lo      in  32  current LO register
//   result  out 64  {hi,lo} value the operation would produce
//                   (divides: {remainder, quotient})
// -----------------------------------------------------------------------------
module md_arith
    import md_pkg::*;
(
    input  logic [MD_OP_W-1:0] op,
    input  logic [31:0]        src_a,
    input  logic [31:0]        src_b,
    input  logic [31:0]        hi,
    input  logic [31:0]        lo,
    output logic [63:0]        result
);

    logic [63:0] acc;
    logic [63:0] ext_a_s;
    logic [63:0] ext_b_s;
    logic [63:0] ext_a_u;
    logic [63:0] ext_b_u;
    logic [63:0] prod_s;
    logic [63:0] prod_u;

    logic        div_signed;
    logic        neg_a;
    logic        neg_b;
    logic        div_zero;
    logic [31:0] mag_a;
    logic [31:0] mag_b;
    logic [31:0] divisor;
    logic [31:0] quo_mag;
    logic [31:0] rem_mag;
    logic [31:0] quo;
    logic [31:0] rem;

    assign acc = {hi, lo};

    // Only the low 64 bits of the product are needed, and the low 64 bits of
    // a product of sign-extended operands equal the signed 32x32 product.
    assign ext_a_s = {{32{src_a[31]}}, src_a};
    assign ext_b_s = {{32{src_b[31]}}, src_b};
    assign ext_a_u = {32'd0, src_a};
    assign ext_b_u = {32'd0, src_b};
    assign prod_s  = ext_a_s * ext_b_s;
    assign prod_u  = ext_a_u * ext_b_u;

    // One unsigned divider serves both div and divu. For signed divides the
    // operands are reduced to magnitudes and the signs are reapplied:
    // quotient negative when the signs differ, remainder follows the dividend.
    // 0x80000000 / -1 falls out naturally: magnitude 0x80000000 / 1, negated
    // back to 0x80000000, remainder 0.
    assign div_signed = (op == 4'(MD_DIV));
    assign neg_a      = div_signed & src_a[31];
    assign neg_b      = div_signed & src_b[31];
    assign mag_a      = neg_a ? (~src_a + 32'd1) : src_a;
    assign mag_b      = neg_b ? (~src_b + 32'd1) : src_b;
    assign div_zero   = (src_b == 32'd0);
    // Keep the divider input defined on divide-by-zero; its output is then
    // discarded in favour of the unchanged accumulator.
    assign divisor    = div_zero ? 32'd1 : mag_b;
    assign quo_mag    = mag_a / divisor;
    assign rem_mag    = mag_a % divisor;
    assign quo        = (neg_a ^ neg_b) ? (~quo_mag + 32'd1) : quo_mag;
    assign rem        = neg_a ? (~rem_mag + 32'd1) : rem_mag;

    always_comb begin
        result = acc;
        case (md_op_e'(op))
            MD_MULT:           result = prod_s;
            MD_MULTU:          result = prod_u;
            MD_MADD:           result = acc + prod_s;
            MD_MADDU:          result = acc + prod_u;
            MD_MSUB:           result = acc - prod_s;
            MD_MSUBU:          result = acc - prod_u;
            MD_DIV, MD_DIVU:   result = div_zero ? acc : {rem, quo};
            default:           result = acc;
        endcase
    end

endmodule : md_arith

// File: rtl/md_sched.sv
// -----------------------------------------------------------------------------
// md_sched
// Multiply/divide sequencer and owner of the HI/LO architectural registers
// for the 5-stage pipeline. A start pulse from E launches one operation; the
// full result is captured at once and released into {hi,lo} after a fixed
// latency modelled by a down-counter. While the unit is busy, D-stage MD
// instructions are held back through stall_req.
//
// Ports:
//   clk        in  1   system clock, rising edge
//   reset      in  1   asynchronous, active-low reset
//   start      in  1   E-stage MD op valid (one-cycle pulse)
//   md_op      in  4   operation code (md_pkg::md_op_e)
//   src_a      in  32  rs operand (forwarded)
//   src_b      in  32  rt operand (forwarded)
//   d_md_use   in  1   D-stage instruction is an MD op
//   flush      in  1   abort in-flight op without commit
//   busy       out 1   unit computing
//   stall_req  out 1   hold the D stage
//   hi         out 32  HI register
//   lo         out 32  LO register
// -----------------------------------------------------------------------------
module md_sched
    import md_pkg::*;
#(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10,
    parameter int CNT_W       = 4
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic [MD_OP_W-1:0] md_op,
    input  logic [31:0]        src_a,
    input  logic [31:0]        src_b,
    input  logic               d_md_use,
    input  logic               flush,
    output logic               busy,
    output logic               stall_req,
    output logic [31:0]        hi,
    output logic [31:0]        lo
);

    md_state_e         state_reg;
    logic [CNT_W-1:0]  cnt_reg;
    logic [63:0]       temp_reg;
    logic [31:0]       hi_reg;
    logic [31:0]       lo_reg;
    logic              busy_reg;

    logic              op_multicycle;
    logic [CNT_W-1:0]  cnt_load;
    logic [63:0]       arith_result;

    assign op_multicycle = is_multicycle(md_op);
    assign cnt_load      = is_divide(md_op) ? CNT_W'(DIV_CYCLES)
                                            : CNT_W'(MULT_CYCLES);

    md_arith u_arith (
        .op     (md_op),
        .src_a  (src_a),
        .src_b  (src_b),
        .hi     (hi_reg),
        .lo     (lo_reg),
        .result (arith_result)
    );

    // Single FSM block: state, counter, temp result and HI/LO all update here
    // so that busy and the architectural registers are plain flops.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_reg <= IDLE;
            cnt_reg   <= '0;
            temp_reg  <= '0;
            hi_reg    <= '0;
            lo_reg    <= '0;
            busy_reg  <= 1'b0;
        end else begin
            case (state_reg)
                IDLE: begin
                    // A flush in the same cycle kills the incoming op.
                    if (start && !flush) begin
                        if (op_multicycle) begin
                            temp_reg  <= arith_result;
                            cnt_reg   <= cnt_load;
                            state_reg <= BUSY;
                            busy_reg  <= 1'b1;
                        end else if (md_op == 4'(MD_MTHI)) begin
                            hi_reg <= src_a;
                        end else if (md_op == 4'(MD_MTLO)) begin
                            lo_reg <= src_a;
                        end
                    end
                end
                BUSY: begin
                    // Starts are not accepted here; the hazard unit never
                    // issues one while busy is high.
                    if (flush) begin
                        // Takes priority over a coincident final cycle.
                        cnt_reg   <= '0;
                        state_reg <= IDLE;
                        busy_reg  <= 1'b0;
                    end else if (cnt_reg == CNT_W'(1)) begin
                        hi_reg    <= temp_reg[63:32];
                        lo_reg    <= temp_reg[31:0];
                        cnt_reg   <= '0;
                        state_reg <= IDLE;
                        busy_reg  <= 1'b0;
                    end else begin
                        cnt_reg <= cnt_reg - CNT_W'(1);
                    end
                end
                default: begin
                    cnt_reg   <= '0;
                    state_reg <= IDLE;
                    busy_reg  <= 1'b0;
                end
            endcase
        end
    end

    // Combinational so the D-stage consumer is held in the very cycle the
    // multi-cycle op is launched; mthi/mtlo complete in one edge and never
    // need to hold anything.
    assign stall_req = d_md_use & (busy_reg | (start & op_multicycle));

    assign busy = busy_reg;
    assign hi   = hi_reg;
    assign lo   = lo_reg;

endmodule : md_sched

// File: tb/tb_md_sched.sv
// -----------------------------------------------------------------------------
// tb_md_sched
// Scoreboard bench for md_sched. The driver issues operations and pushes the
// expected {hi,lo} plus the cycle at which it must be visible; a monitor on
// the falling edge checks busy/stall_req every cycle and pops/compares each
// entry when its due cycle arrives.
// -----------------------------------------------------------------------------
module tb_md_sched;

    localparam logic [3:0] OP_MULT  = 4'd0;
    localparam logic [3:0] OP_MULTU = 4'd1;
    localparam logic [3:0] OP_DIV   = 4'd2;
    localparam logic [3:0] OP_DIVU  = 4'd3;
    localparam logic [3:0] OP_MADD  = 4'd4;
    localparam logic [3:0] OP_MADDU = 4'd5;
    localparam logic [3:0] OP_MSUB  = 4'd6;
    localparam logic [3:0] OP_MSUBU = 4'd7;
    localparam logic [3:0] OP_MTHI  = 4'd8;
    localparam logic [3:0] OP_MTLO  = 4'd9;
    localparam int MULT_N = 5;
    localparam int DIV_N  = 10;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [3:0]  md_op;
    logic [31:0] src_a;
    logic [31:0] src_b;
    logic        d_md_use;
    logic        flush;
    logic        busy;
    logic        stall_req;
    logic [31:0] hi;
    logic [31:0] lo;

    always #5 clk = ~clk;

    md_sched dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .md_op     (md_op),
        .src_a     (src_a),
        .src_b     (src_b),
        .d_md_use  (d_md_use),
        .flush     (flush),
        .busy      (busy),
        .stall_req (stall_req),
        .hi        (hi),
        .lo        (lo)
    );

    typedef struct {
        int          st;    // cycle number right after the start edge
        int          due;   // cycle number at which {hi,lo} must match
        bit          mc;    // unit expected busy over [st, due)
        logic [31:0] hi;
        logic [31:0] lo;
    } exp_t;

    exp_t        q[$];
    int          cyc = 0;
    int          n_checks = 0;
    int          n_fail = 0;
    logic [31:0] model_hi = '0;
    logic [31:0] model_lo = '0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s cyc=%0d actual=%h required=%h", name, cyc, act, exp);
        end
    endtask

    // Reference arithmetic straight from the operation definitions.
    function automatic logic [63:0] ref_md(input logic [3:0] op, input logic [31:0] a,
                                           input logic [31:0] b, input logic [63:0] acc);
        longint      sa, sb, sq, sr;
        logic [63:0] ua, ub, ps, pu, uq, ur;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ua = {32'd0, a};
        ub = {32'd0, b};
        ps = 64'(sa * sb);
        pu = ua * ub;
        case (op)
            OP_MULT:  return ps;
            OP_MULTU: return pu;
            OP_MADD:  return acc + ps;
            OP_MADDU: return acc + pu;
            OP_MSUB:  return acc - ps;
            OP_MSUBU: return acc - pu;
            OP_DIV: begin
                if (b == 32'd0) return acc;
                sq = sa / sb;
                sr = sa % sb;
                return {sr[31:0], sq[31:0]};
            end
            OP_DIVU: begin
                if (b == 32'd0) return acc;
                uq = ua / ub;
                ur = ua % ub;
                return {ur[31:0], uq[31:0]};
            end
            default: return acc;
        endcase
    endfunction

    // Monitor: per-cycle busy/stall checks and due-cycle result checks.
    bit model_busy;
    always @(negedge clk) begin
        if (reset === 1'b1) begin
            model_busy = (q.size() > 0) && q[0].mc && (cyc >= q[0].st) && (cyc < q[0].due);
            chk("busy", 64'(busy), 64'(model_busy));
            chk("stall_req", 64'(stall_req),
                64'(d_md_use & (model_busy | (start & (md_op <= OP_MSUBU)))));
            if (q.size() > 0 && q[0].due == cyc) begin
                chk("hilo", {hi, lo}, {q[0].hi, q[0].lo});
                $display("txn cyc=%0d start=%0d hi=%h lo=%h exp_hi=%h exp_lo=%h",
                         cyc, q[0].st, hi, lo, q[0].hi, q[0].lo);
                void'(q.pop_front());
            end
        end
    end

    // Issue one operation. fl_start: flush together with start.
    // fl_k in 1..latency: flush edge lands fl_k edges after the start edge.
    task automatic send(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                        input logic dmu, input bit fl_start, input int fl_k);
        exp_t        e;
        logic [63:0] r;
        int          n;
        bit          do_fl;
        @(posedge clk); #1;
        start    = 1'b1;
        md_op    = op;
        src_a    = a;
        src_b    = b;
        d_md_use = dmu;
        flush    = fl_start;
        e.st  = cyc + 1;
        e.due = e.st;
        e.mc  = 1'b0;
        do_fl = 1'b0;
        if (!fl_start) begin
            if (op == OP_MTHI) model_hi = a;
            else if (op == OP_MTLO) model_lo = a;
            else if (op <= OP_MSUBU) begin
                n = (op == OP_DIV || op == OP_DIVU) ? DIV_N : MULT_N;
                e.mc = 1'b1;
                if (fl_k >= 1 && fl_k <= n) begin
                    do_fl = 1'b1;
                    e.due = e.st + fl_k;
                end else begin
                    e.due = e.st + n;
                    r = ref_md(op, a, b, {model_hi, model_lo});
                    model_hi = r[63:32];
                    model_lo = r[31:0];
                end
            end
        end
        e.hi = model_hi;
        e.lo = model_lo;
        q.push_back(e);
        @(posedge clk); #1;
        start = 1'b0;
        flush = 1'b0;
        if (do_fl) begin
            repeat (fl_k - 1) begin @(posedge clk); #1; end
            flush = 1'b1;
            @(posedge clk); #1;
            flush = 1'b0;
        end
    endtask

    task automatic wait_done();
        for (int t = 0; t < 40 && q.size() != 0; t++) @(posedge clk);
        #1;
        chk("done_in_time", 64'(q.size()), 64'd0);
        q.delete();
    endtask

    task automatic run(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic dmu, input bit fl_start, input int fl_k);
        send(op, a, b, dmu, fl_start, fl_k);
        wait_done();
    endtask

    function automatic logic [31:0] pick();
        case ($urandom_range(0, 5))
            0:       return 32'h0000_0000;
            1:       return 32'h8000_0000;
            2:       return 32'hFFFF_FFFF;
            3:       return 32'($urandom_range(0, 20));
            default: return $urandom;
        endcase
    endfunction

    initial begin
        start    = 1'b0;
        md_op    = 4'd0;
        src_a    = '0;
        src_b    = '0;
        d_md_use = 1'b1;
        flush    = 1'b0;
        reset    = 1'b1;
        #1 reset = 1'b0;
        #2;
        chk("reset_busy", 64'(busy), 64'd0);
        chk("reset_stall", 64'(stall_req), 64'd0);
        chk("reset_hilo", {hi, lo}, 64'd0);
        repeat (2) @(posedge clk);
        #2 reset = 1'b1;

        // Directed cases.
        run(OP_MULT, 32'hFFFF_FFFE, 32'd3, 1'b1, 1'b0, 0);
        chk("mult_neg2x3", {hi, lo}, 64'hFFFF_FFFF_FFFF_FFFA);
        run(OP_MULTU, 32'hFFFF_FFFE, 32'd3, 1'b1, 1'b0, 0);
        chk("multu_x3", {hi, lo}, 64'h0000_0002_FFFF_FFFA);
        run(OP_DIV, 32'hFFFF_FFF9, 32'd2, 1'b1, 1'b0, 0);
        chk("div_neg7_2", {hi, lo}, 64'hFFFF_FFFF_FFFF_FFFD);
        run(OP_MTHI, 32'h11, 32'd0, 1'b0, 1'b0, 0);
        run(OP_MTLO, 32'h22, 32'd0, 1'b0, 1'b0, 0);
        run(OP_DIVU, 32'd7, 32'd0, 1'b1, 1'b0, 0);
        chk("divu_by_zero", {hi, lo}, 64'h0000_0011_0000_0022);
        run(OP_MTHI, 32'hDEAD_BEEF, 32'd0, 1'b1, 1'b0, 0);
        run(OP_MTLO, 32'h0, 32'd0, 1'b1, 1'b0, 0);
        run(OP_MADDU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 1'b0, 0);
        chk("maddu_wrap", {hi, lo}, 64'hDEAD_BEED_0000_0001);
        run(OP_DIV, 32'd100, 32'd7, 1'b1, 1'b0, 4);
        chk("div_flush4", {hi, lo}, 64'hDEAD_BEED_0000_0001);
        run(OP_DIV, 32'd100, 32'd7, 1'b1, 1'b0, DIV_N);
        chk("div_flush_last", {hi, lo}, 64'hDEAD_BEED_0000_0001);
        run(OP_MULT, 32'd9, 32'd9, 1'b1, 1'b1, 0);
        chk("idle_flush_start", {hi, lo}, 64'hDEAD_BEED_0000_0001);
        run(OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 1'b0, 0);
        chk("div_overflow", {hi, lo}, 64'h0000_0000_8000_0000);
        run(4'd12, 32'd1, 32'd1, 1'b1, 1'b0, 0);
        chk("undef_op", {hi, lo}, 64'h0000_0000_8000_0000);
        run(OP_MSUB, 32'd1, 32'd1, 1'b0, 1'b0, 0);
        chk("msub_1", {hi, lo}, 64'h0000_0000_7FFF_FFFF);

        // Reset in the middle of a mult, then a clean mult afterwards.
        send(OP_MULT, 32'd1234, 32'd5678, 1'b1, 1'b0, 0);
        repeat (2) @(posedge clk);
        @(negedge clk); #2;
        reset = 1'b0;
        #1;
        chk("async_rst_busy", 64'(busy), 64'd0);
        chk("async_rst_hilo", {hi, lo}, 64'd0);
        q.delete();
        model_hi = '0;
        model_lo = '0;
        @(posedge clk);
        @(negedge clk); #2;
        reset = 1'b1;
        run(OP_MULT, 32'd1234, 32'd5678, 1'b1, 1'b0, 0);
        chk("mult_after_rst", {hi, lo}, 64'd7006652);

        // Randomized traffic against the reference model.
        for (int i = 0; i < 60; i++) begin
            logic [3:0] rop;
            bit         rfs;
            int         rfk;
            rop = 4'($urandom_range(0, 11));
            rfs = ($urandom_range(0, 15) == 0);
            rfk = ($urandom_range(0, 5) == 0) ? $urandom_range(1, 10) : 0;
            run(rop, pick(), pick(), 1'($urandom_range(0, 1)), rfs, rfk);
            repeat ($urandom_range(0, 2)) @(posedge clk);
        end

        chk("scoreboard_empty", 64'(q.size()), 64'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule : tb_md_sched
